ramp_step_gen: RTL and testbench
================================

Name: ramp_step_gen

Overview:
Parametrised successor to the fixed-rate acc_step_gen. Generates step strobes whose period changes linearly per step (constant-delta ramp), so accel/decel segments need no software loop. A one-deep shadow command register with valid/ready handshake chains segments with zero gap. Sits between the motion command FIFO/bus regs and the stepper driver output stage, one instance per axis.

Parameters:
W, 32, width of period, step-count and timer registers
DW, 16, width of signed per-step period delta (ddt)
DT_MIN, 2, minimum legal period in clocks; all periods clamp to >= DT_MIN

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_dt  in  W  starting period (clocks between steps) of segment
cmd_ddt  in  DW  signed delta added to period after each step
cmd_steps  in  W  number of steps in segment
cmd_dir  in  1  direction for segment
cmd_valid  in  1  command present
cmd_ready  out  1  shadow register empty; command accepted when cmd_valid && cmd_ready
abort  in  1  synchronous abort; clears active and shadow segments
steps  out  W  steps remaining in active segment
dt  out  W  current active period
dir  out  1  direction of active segment
stopped  out  1  high when no segment active
step_stb  out  1  one-cycle step pulse
done  out  1  one-cycle pulse when a segment completes

Behaviour:
- Reset values: steps=0, dt=0, dir=0, stopped=1, step_stb=0, done=0, cmd_ready=1, timer=0, shadow empty, state IDLE.
- Accept: on edge with cmd_valid&&cmd_ready, shadow <= {max(cmd_dt,DT_MIN), cmd_ddt, cmd_steps, cmd_dir}; cmd_ready=0 next cycle. cmd_ready = !shadow_valid (registered).
- States: IDLE, RUN.
- IDLE: if shadow_valid, transfer shadow->active next edge, timer <= dt, stopped <= 0, go RUN. Latency: command accepted at edge N -> active at N+1 -> first step_stb at N+1+dt.
- RUN: timer decrements each clock; on timer==1: step_stb=1, steps<=steps-1, dt<=sat(dt+ddt), timer<=new dt.
- sat: signed add of sign-extended ddt, result clamped to [DT_MIN, 2^W-1]; no wrap.
- Last step (steps==1 at strobe): done=1 in same cycle as step_stb. If shadow_valid, transfer shadow->active in that same edge with timer<=shadow dt (no gap; next step exactly shadow dt clocks later); stay RUN. Else go IDLE, stopped<=1, steps=0, dt holds last value.
- Command accepted in the same cycle as last step: shadow not yet valid at that edge; goes IDLE for one cycle then loads (one-cycle gap allowed).
- cmd_steps==0: on transfer, done pulses for one cycle, no step_stb, segment skipped; shadow follow-up loads next edge.
- abort: highest priority; next edge steps=0, shadow cleared, cmd_ready=1, state IDLE, stopped=1; no done, no step_stb in abort cycle. Simultaneous cmd_valid dropped.
- Async reset mid-operation: all outputs to reset values immediately, strobe in flight lost.
- dir changes only on segment transfer; stable for whole segment.

Optional Feature:
MOTION_POS_COUNTER_EN: when defined, adds output pos (W, signed) and input pos_clr; pos increments on step_stb with dir=1, decrements with dir=0, wraps modulo 2^W; pos_clr synchronous, abort does not clear pos, reset sets 0. When undefined, port and counter absent; no other change.

Decomposition:
- Shared motion package/include: W/DW defaults, DT_MIN, IDLE/RUN state encoding, segment field layout constants, common with acc_step_gen users.
- One sub-module natural: step_sat_add (combinational signed add + clamp to [DT_MIN, 2^W-1]), reused by future multi-axis blocks.

Test Plan:
- cmd dt=20, ddt=0, steps=20 at cycle 0 -> first step_stb at cycle 21, then every 20 clocks, 20 strobes, done with 20th, stopped=1 after.
- dt=100, ddt=-10, steps=5 -> strobe intervals 100,90,80,70,60; final dt=50.
- dt=5, ddt=-4, DT_MIN=2, steps=4 -> intervals 5,2,2,2; dt=0 command -> period 2; dt=2^32-2, ddt=+5 -> clamps at 2^32-1.
- Segment A (dt=10, steps=3) running, B (dt=7, steps=2) queued -> strobes at +10,+20,+30 then +37,+44; no gap, cmd_ready low while B shadowed, done pulses twice.
- abort mid-segment with queued shadow -> no further strobes, stopped=1, cmd_ready=1 next cycle, no done; steps=0 command -> single done, no strobe.
- reset asserted mid-RUN asynchronously -> outputs to reset values without clock edge; with MOTION_POS_COUNTER_EN, 3 steps dir=1 then 5 dir=0 -> pos=-2.

Source files
------------

// File: rtl/ramp_step_gen_pkg.sv
// ramp_step_gen_pkg
// Shared motion definitions for the ramp/step generators: default widths,
// the minimum legal step period, and the sequencer state encoding.
package ramp_step_gen_pkg;

    localparam int W_DEF      = 32;  // period, step-count and timer width
    localparam int DW_DEF     = 16;  // signed per-step period delta width
    localparam int DT_MIN_DEF = 2;   // smallest period the output stage can follow

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ramp_step_gen_step_sat_add.sv
// step_sat_add
// Combinational period update: a + sign-extended d, clamped to
// [DT_MIN, 2^W-1]. The sum is formed two bits wider than W so that both
// the underflow (negative) and the overflow cases are visible before the
// clamp and nothing wraps.
// Ports:
//   a  in  W   current period (unsigned)
//   d  in  DW  signed delta
//   y  out W   clamped next period
module step_sat_add
    import ramp_step_gen_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int DW     = DW_DEF,
    parameter int DT_MIN = DT_MIN_DEF
) (
    input  logic [W-1:0]  a,
    input  logic [DW-1:0] d,
    output logic [W-1:0]  y
);

    localparam logic signed [W+1:0] LO = (W+2)'(DT_MIN);
    localparam logic signed [W+1:0] HI = {2'b00, {W{1'b1}}};

    logic signed [W+1:0] sum;

    always_comb begin
        sum = $signed({2'b00, a}) + $signed({{(W+2-DW){d[DW-1]}}, d});
        if (sum < LO) begin
            y = W'(DT_MIN);
        end else if (sum > HI) begin
            y = '1;
        end else begin
            y = sum[W-1:0];
        end
    end

endmodule

// File: rtl/ramp_step_gen.sv
// ramp_step_gen
// Step strobe generator whose period changes by a constant signed delta
// after every step. A one-deep shadow command register lets the next
// segment start on the exact clock the current one finishes.
// Optional build macro: MOTION_POS_COUNTER_EN adds a signed position
// counter (pos) with synchronous clear (pos_clr).
// Ports:
//   clk, reset                 clock, async active-high reset
//   cmd_dt/ddt/steps/dir       segment command fields
//   cmd_valid / cmd_ready      command handshake (ready = shadow empty)
//   abort                      sync abort, clears active and shadow
//   steps, dt, dir             active segment status
//   stopped                    no segment active
//   step_stb, done             one-cycle step and segment-complete pulses
//   pos_clr, pos               position counter (macro only)
module ramp_step_gen
    import ramp_step_gen_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int DW     = DW_DEF,
    parameter int DT_MIN = DT_MIN_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [W-1:0]        cmd_dt,
    input  logic [DW-1:0]       cmd_ddt,
    input  logic [W-1:0]        cmd_steps,
    input  logic                cmd_dir,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                abort,
`ifdef MOTION_POS_COUNTER_EN
    input  logic                pos_clr,
    output logic signed [W-1:0] pos,
`endif
    output logic [W-1:0]        steps,
    output logic [W-1:0]        dt,
    output logic                dir,
    output logic                stopped,
    output logic                step_stb,
    output logic                done
);

    state_t         state, state_nxt;
    logic [W-1:0]   timer;
    logic [DW-1:0]  ddt;
    logic           sh_valid;
    logic [W-1:0]   sh_dt;
    logic [DW-1:0]  sh_ddt;
    logic [W-1:0]   sh_steps;
    logic           sh_dir;
    logic           load;
    logic [W-1:0]   dt_sat;

    step_sat_add #(.W(W), .DW(DW), .DT_MIN(DT_MIN)) u_sat (
        .a (dt),
        .d (ddt),
        .y (dt_sat)
    );

    assign cmd_ready = !sh_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A segment ends either on its last strobe or, for a zero-step segment,
    // on the first RUN cycle. Either way the shadow is pulled in on the same
    // edge so chained segments have no gap.
    always_comb begin
        state_nxt = state;
        step_stb  = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sh_valid) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (steps == '0) begin
                        done = 1'b1;
                        if (sh_valid) load = 1'b1;
                        else          state_nxt = IDLE;
                    end else if (timer == W'(1)) begin
                        step_stb = 1'b1;
                        if (steps == W'(1)) begin
                            done = 1'b1;
                            if (sh_valid) load = 1'b1;
                            else          state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            steps    <= '0;
            dt       <= '0;
            ddt      <= '0;
            dir      <= 1'b0;
            timer    <= '0;
            stopped  <= 1'b1;
            sh_valid <= 1'b0;
            sh_dt    <= '0;
            sh_ddt   <= '0;
            sh_steps <= '0;
            sh_dir   <= 1'b0;
        end else if (abort) begin
            steps    <= '0;
            stopped  <= 1'b1;
            sh_valid <= 1'b0;
        end else begin
            if (load) begin
                steps    <= sh_steps;
                dt       <= sh_dt;
                ddt      <= sh_ddt;
                dir      <= sh_dir;
                timer    <= sh_dt;
                sh_valid <= 1'b0;
            end else if (step_stb) begin
                steps <= steps - W'(1);
                dt    <= dt_sat;
                timer <= dt_sat;
            end else if (state == RUN) begin
                timer <= timer - W'(1);
            end
            // Accept and load are exclusive: accept needs an empty shadow,
            // load needs a full one.
            if (cmd_valid && !sh_valid) begin
                sh_valid <= 1'b1;
                sh_dt    <= (cmd_dt < W'(DT_MIN)) ? W'(DT_MIN) : cmd_dt;
                sh_ddt   <= cmd_ddt;
                sh_steps <= cmd_steps;
                sh_dir   <= cmd_dir;
            end
            stopped <= (state_nxt == IDLE);
        end
    end

`ifdef MOTION_POS_COUNTER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= '0;
        end else if (pos_clr) begin
            pos <= '0;
        end else if (step_stb) begin
            pos <= dir ? pos + W'(1) : pos - W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ramp_step_gen.sv
module tb_ramp_step_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cmd_dt = '0;
    logic [15:0] cmd_ddt = '0;
    logic [31:0] cmd_steps = '0;
    logic        cmd_dir = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        abort = 1'b0;
    logic        cmd_ready;
    logic [31:0] steps;
    logic [31:0] dt;
    logic        dir;
    logic        stopped;
    logic        step_stb;
    logic        done;
`ifdef MOTION_POS_COUNTER_EN
    logic               pos_clr = 1'b0;
    logic signed [31:0] pos;
`endif

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    longint stb_q[$];
    bit     dir_q[$];
    longint done_q[$];
    longint exp_stb[$];
    bit     exp_dir[$];
    longint exp_done[$];

    logic [31:0] sa;
    logic [15:0] sd;
    logic [31:0] sy;

    ramp_step_gen dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_dt    (cmd_dt),
        .cmd_ddt   (cmd_ddt),
        .cmd_steps (cmd_steps),
        .cmd_dir   (cmd_dir),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .abort     (abort),
`ifdef MOTION_POS_COUNTER_EN
        .pos_clr   (pos_clr),
        .pos       (pos),
`endif
        .steps     (steps),
        .dt        (dt),
        .dir       (dir),
        .stopped   (stopped),
        .step_stb  (step_stb),
        .done      (done)
    );

    step_sat_add #(.W(32), .DW(16), .DT_MIN(2)) u_sat (
        .a (sa),
        .d (sd),
        .y (sy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Events are logged by the edge on which they take effect.
    always @(negedge clk) begin
        if (!reset) begin
            if (step_stb) begin
                stb_q.push_back(cyc + 1);
                dir_q.push_back(dir);
            end
            if (done) done_q.push_back(cyc + 1);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint clampp(input longint v);
        if (v < 2) return 2;
        if (v > 64'hFFFF_FFFF) return 64'hFFFF_FFFF;
        return v;
    endfunction

    // Reference: a segment loaded at edge L strobes at L + cumulative periods.
    task automatic model_seg(input longint l, input longint d, input int dd, input longint n,
                             input bit dr, output longint e_end, output longint fdt);
        longint p = clampp(d);
        longint e = l;
        for (longint k = 0; k < n; k++) begin
            e += p;
            exp_stb.push_back(e);
            exp_dir.push_back(dr);
            p = clampp(p + dd);
        end
        if (n == 0) e = l + 1;
        exp_done.push_back(e);
        e_end = e;
        fdt = p;
    endtask

    // Called at a negedge; returns at a negedge with acc = accepting edge.
    task automatic send(input longint d, input int dd, input longint n, input bit dr, output longint acc);
        int guard = 0;
        cmd_dt = 32'(d);
        cmd_ddt = 16'(dd);
        cmd_steps = 32'(n);
        cmd_dir = dr;
        cmd_valid = 1'b1;
        acc = -1;
        while (acc < 0 && guard < 2000) begin
            if (cmd_ready) acc = cyc + 1;
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b0;
        chk("send_accepted", 64'(acc >= 0), 64'd1);
    endtask

    task automatic clear_logs();
        stb_q.delete();
        dir_q.delete();
        done_q.delete();
        exp_stb.delete();
        exp_dir.delete();
        exp_done.delete();
    endtask

    task automatic run_scn(input string tag,
                           input longint da, input int dda, input longint na, input bit ra,
                           input bit two,
                           input longint db, input int ddb, input longint nb, input bit rb);
        longint acc_a, acc_b, e_end, fdt;
        int n;
        clear_logs();
        send(da, dda, na, ra, acc_a);
        acc_b = 0;
        if (two) begin
            send(db, ddb, nb, rb, acc_b);
            chk({tag, "_ready_low"}, 64'(cmd_ready), 64'd0);
        end
        model_seg(acc_a + 1, da, dda, na, ra, e_end, fdt);
        if (two) model_seg(e_end, db, ddb, nb, rb, e_end, fdt);
        while (cyc < e_end + 2) @(negedge clk);
        chk({tag, "_nstb"}, 64'(stb_q.size()), 64'(exp_stb.size()));
        n = (stb_q.size() < exp_stb.size()) ? stb_q.size() : exp_stb.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_stb%0d", tag, i), stb_q[i], exp_stb[i]);
            chk($sformatf("%s_dir%0d", tag, i), 64'(dir_q[i]), 64'(exp_dir[i]));
        end
        chk({tag, "_ndone"}, 64'(done_q.size()), 64'(exp_done.size()));
        n = (done_q.size() < exp_done.size()) ? done_q.size() : exp_done.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_done%0d", tag, i), done_q[i], exp_done[i]);
        chk({tag, "_dt"}, 64'(dt), fdt);
        chk({tag, "_steps"}, 64'(steps), 64'd0);
        chk({tag, "_stopped"}, 64'(stopped), 64'd1);
        chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        longint acc_a, acc_b, va;
        int vd;

        // saturating adder, directly
        for (int i = 0; i < 12; i++) begin
            case (i)
                0: begin va = 64'hFFFF_FFFE; vd = 5; end
                1: begin va = 5; vd = -4; end
                2: begin va = 3; vd = -100; end
                3: begin va = 100; vd = -10; end
                4: begin va = 64'hFFFF_FFFF; vd = -32768; end
                5: begin va = 2; vd = 0; end
                default: begin va = longint'($urandom); vd = int'($urandom_range(0, 65535)) - 32768; end
            endcase
            sa = 32'(va);
            sd = 16'(vd);
            #1;
            chk($sformatf("sat%0d", i), 64'(sy), clampp(va + vd));
        end

        repeat (3) @(negedge clk);
        chk("rst_steps", 64'(steps), 64'd0);
        chk("rst_dt", 64'(dt), 64'd0);
        chk("rst_dir", 64'(dir), 64'd0);
        chk("rst_stopped", 64'(stopped), 64'd1);
        chk("rst_stb", 64'(step_stb), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_scn("const",    20,   0, 20, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        run_scn("decel",   100, -10,  5, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_scn("clamp_lo",  5,  -4,  4, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        run_scn("dt0",       0,   0,  3, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_scn("chain",    10,   0,  3, 1'b1, 1'b1, 7, 0, 2, 1'b0);
        run_scn("zero",     15,   3,  0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        run_scn("chain0",    6,   1,  2, 1'b0, 1'b1, 9, 0, 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            run_scn($sformatf("rnd%0d", r),
                    longint'($urandom_range(0, 30)), int'($urandom_range(0, 20)) - 10,
                    longint'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                    1'b1,
                    longint'($urandom_range(0, 30)), int'($urandom_range(0, 20)) - 10,
                    longint'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end

`ifdef MOTION_POS_COUNTER_EN
        pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        run_scn("pos", 5, 0, 3, 1'b1, 1'b1, 5, 0, 5, 1'b0);
        chk("pos_value", 64'(32'(pos)), 64'h0000_0000_FFFF_FFFE);
`endif

        // abort while the second strobe is due and a segment is shadowed
        clear_logs();
        send(10, 0, 5, 1'b1, acc_a);
        send(7, 0, 2, 1'b0, acc_b);
        chk("abort_ready_low", 64'(cmd_ready), 64'd0);
        while (cyc < acc_a + 19) @(negedge clk);
        @(posedge clk);
        #1;
        abort = 1'b1;
        #1;
        chk("abort_pre_steps", 64'(steps), 64'd4);
        chk("abort_no_stb", 64'(step_stb), 64'd0);
        chk("abort_no_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_stopped", 64'(stopped), 64'd1);
        chk("abort_steps", 64'(steps), 64'd0);
        chk("abort_ready", 64'(cmd_ready), 64'd1);
        repeat (60) @(negedge clk);
        chk("abort_nstb", 64'(stb_q.size()), 64'd1);
        chk("abort_ndone", 64'(done_q.size()), 64'd0);
        chk("abort_still_stopped", 64'(stopped), 64'd1);

        // asynchronous reset in the middle of a run
        clear_logs();
        send(10, 0, 5, 1'b1, acc_a);
        repeat (15) @(negedge clk);
        chk("pre_reset_running", 64'(stopped), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_steps", 64'(steps), 64'd0);
        chk("areset_dt", 64'(dt), 64'd0);
        chk("areset_dir", 64'(dir), 64'd0);
        chk("areset_stopped", 64'(stopped), 64'd1);
        chk("areset_stb", 64'(step_stb), 64'd0);
        chk("areset_ready", 64'(cmd_ready), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
